// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a word-addressable data memory.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module dmem_lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Both decoded purely from state so they cannot glitch on request inputs.
    assign req_ready = (state_q == StIdle);
    assign mem_we    = (state_q == StWrite);
    assign accept    = req_valid & req_ready;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        load_val = mem_rdata;
        case (size_q)
            2'b00: load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01: load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the read word passes through.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= 16'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_adr   <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        rsp_err   <= req_err;
                        rsp_rdata <= 32'h0;
                        if (req_err) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            mem_adr <= {req_addr[31:2], 2'b00};
                            if (req_we && req_size == 2'b10) begin
                                mem_wdata <= req_wdata;
                                state_q   <= StWrite;
                            end else begin
                                state_q <= StRead;
                            end
                        end
                    end
                end
                StRead: begin
                    if (we_q) begin
                        mem_wdata <= merged;
                        state_q   <= StWrite;
                    end else begin
                        rsp_rdata <= load_val;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StWrite: begin
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
